controle_venda: RTL and testbench
=================================

Name: controle_venda

Overview:
- Vending-transaction sequencer. It is the consumer side of the phase-strobe timer.
- Drives the 2-bit `estado` bus that starts and stops the timer.
- Reacts once per falling edge of the timer's three active-low phase strobes: `tempoTeclado` (sample keypad), `tempoAcumulador` (credit pending coin) and `tempo` (decide).
- Sequences coin accumulation, product release and change return.

Parameters:
- PRECO, 150, product price in cents. Must be a multiple of 25 and ≤ CREDITO_MAX.
- CREDITO_MAX, 200, credit ceiling in cents (≤ 255).
- PRODUTOS, 9, highest valid product code on `tecla`.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- tempoTeclado  in  1  active-low keypad phase strobe from timer.
- tempoAcumulador  in  1  active-low accumulate phase strobe from timer.
- tempo  in  1  active-low decision phase strobe from timer.
- moeda  in  2  coin sensor code: 00 none, 01 = 25, 10 = 50, 11 = 100 cents.
- tecla  in  4  keypad code: 0 none, 1..PRODUTOS valid.
- cancelar  in  1  cancel request, level.
- estado  out  2  state to timer: 0 OCIOSO, 1 COLETA, 2 VENDA, 3 TROCO.
- credito  out  8  current credit in cents.
- produto  out  4  product code, valid with `liberar`.
- liberar  out  1  one-cycle release pulse.
- troco  out  8  change in cents, valid with `troco_valido`.
- troco_valido  out  1  one-cycle change pulse.
- erro  out  1  one-cycle pulse: coin rejected (would exceed CREDITO_MAX).

Behaviour:
- **Reset** (rst_n = 0 at clk edge):
  - state OCIOSO; `credito`, `produto`, `troco` = 0; all pulses = 0.
  - Pending coin, selected product and cancel latch cleared.
  - Strobe history registers = 1.
  - Mid-transaction reset discards credit with no `troco_valido`.
- **Edge detection:** a strobe event is previous = 1 and current = 0. A level held low for several cycles counts once.
- **Coin capture**, any state except VENDA/TROCO: if `moeda` ≠ 00 and no coin is pending, latch the coin as pending. Further coins are ignored while one is pending (the sensor holds its code until the coin is counted).
- **Cancel:** `cancelar` = 1 in any cycle sets the cancel latch.
- **OCIOSO** (estado 0, timer halted):
  - pending coin, `tecla` ≠ 0, or cancel latch → COLETA next cycle.
  - Nothing is credited in OCIOSO.
- **COLETA** (estado 1):
  - `tempoTeclado` event: if 1 ≤ `tecla` ≤ PRODUTOS, latch the selection (last key wins). Otherwise keep the previous selection.
  - `tempoAcumulador` event with coin pending:
    - if `credito` + value ≤ CREDITO_MAX, then `credito` += value;
    - otherwise `erro` pulses and `credito` is unchanged.
    - Either way the pending coin is cleared.
  - `tempo` event, in priority order:
    1. cancel latch → TROCO;
    2. selection ≠ 0 and `credito` ≥ PRECO → VENDA;
    3. else stay in COLETA.
    - The decision uses `credito` as registered before any same-cycle update.
- **VENDA** (estado 2), exactly 1 cycle: `liberar` = 1, `produto` = selection, `credito` −= PRECO; → TROCO.
- **TROCO** (estado 3), exactly 1 cycle:
  - `troco` = `credito` and `troco_valido` = 1, even when the value is 0.
  - `credito`, selection, cancel latch and pending coin cleared; → OCIOSO.
- **Simultaneous events:** if more than one strobe event occurs in the same cycle, apply keypad, then accumulator, then decision. The `credito` value used by the decision is still the pre-update one.
- **Output hold:** `troco` and `produto` keep their last values until overwritten. Pulses are 0 in all other cycles.
- **Arithmetic:** `credito` is 8-bit unsigned; saturation is by rejection, so it never wraps.

Decomposition:
- Shared package `venda_pkg`:
  - state encodings OCIOSO/COLETA/VENDA/TROCO (must match the timer's `estado` == 0 idle meaning);
  - coin codes and the coin value constants 25/50/100.
- Sub-module `detector_borda`: 1-bit registered falling-edge detector with synchronous active-low reset (history = 1). Instantiated three times.

Test Plan:
- Reset with all strobes held high, then release → `estado` = 0, `credito` = 0, no pulses for 20 cycles.
- Coins 50, 100 (each held until counted), `tecla` = 3, timer running → `credito` 50 then 150. On the next `tempo` event: `liberar` pulse, `produto` = 3, then `troco_valido` pulse with `troco` = 0, `estado` back to 0.
- Coins 100, 100, then a 25 → `credito` = 200, `erro` pulses once on the 25, `credito` stays 200. Then `tecla` = 1 → `liberar`, followed by `troco` = 50.
- Coin 50, then `cancelar` pulse → no `liberar`; at the next `tempo` event `troco_valido` with `troco` = 50 and `credito` = 0.
- `tempoAcumulador` held low for 4 cycles with one coin pending → credited exactly once (+25 only).
- Coin 100 credited, then rst_n low for 1 cycle mid-COLETA → `credito` = 0, `estado` = 0, no `troco_valido` pulse.

Source files
------------

// File: rtl/venda_pkg.sv
// Shared types for the vending transaction sequencer:
// state encoding toward the timer and coin codes/values.
package venda_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    COLETA = 2'd1,
    VENDA  = 2'd2,
    TROCO  = 2'd3
  } estado_t;

  localparam logic [1:0] MOEDA_NADA = 2'b00;
  localparam logic [1:0] MOEDA_25   = 2'b01;
  localparam logic [1:0] MOEDA_50   = 2'b10;
  localparam logic [1:0] MOEDA_100  = 2'b11;

  localparam logic [7:0] VALOR_25  = 8'd25;
  localparam logic [7:0] VALOR_50  = 8'd50;
  localparam logic [7:0] VALOR_100 = 8'd100;

  function automatic logic [7:0] valor_moeda(
    input logic [1:0] m
  );
    logic [7:0] v;
    v = 8'd0;
    unique case (m)
      MOEDA_25:  v = VALOR_25;
      MOEDA_50:  v = VALOR_50;
      MOEDA_100: v = VALOR_100;
      default:   v = 8'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/controle_venda_detector_borda.sv
// Falling-edge detector for one active-low strobe;
// history resets to 1 so a low level at reset release is seen once.
module detector_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic sinal,
  output logic borda
);

  logic anterior;

  always_ff @(posedge clk) begin
    if (!rst_n)
      anterior <= 1'b1;
    else
      anterior <= sinal;
  end

  assign borda = anterior & ~sinal;

endmodule

// File: rtl/controle_venda.sv
// Vending sequencer: collects coins and a product key on timer
// phase strobes, then releases the product and returns change.
module controle_venda
  import venda_pkg::*;
#(
  parameter int PRECO       = 150,
  parameter int CREDITO_MAX = 200,
  parameter int PRODUTOS    = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tempoTeclado,
  input  logic       tempoAcumulador,
  input  logic       tempo,
  input  logic [1:0] moeda,
  input  logic [3:0] tecla,
  input  logic       cancelar,
  output logic [1:0] estado,
  output logic [7:0] credito,
  output logic [3:0] produto,
  output logic       liberar,
  output logic [7:0] troco,
  output logic       troco_valido,
  output logic       erro
);

  localparam logic [7:0] PRECO_V  = 8'(PRECO);
  localparam logic [8:0] MAX_V    = 9'(CREDITO_MAX);
  localparam logic [3:0] PROD_MAX = 4'(PRODUTOS);

  estado_t    est;
  logic [1:0] pendente;
  logic [3:0] selecao;
  logic       cancela;
  logic       ev_tecl;
  logic       ev_acum;
  logic       ev_dec;
  logic [3:0] sel_nxt;
  logic [8:0] soma;

  detector_borda u_tecl (
    .clk   (clk),
    .rst_n (rst_n),
    .sinal (tempoTeclado),
    .borda (ev_tecl)
  );

  detector_borda u_acum (
    .clk   (clk),
    .rst_n (rst_n),
    .sinal (tempoAcumulador),
    .borda (ev_acum)
  );

  detector_borda u_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .sinal (tempo),
    .borda (ev_dec)
  );

  // Keypad applies before the decision in the same cycle.
  always_comb begin
    sel_nxt = selecao;
    if (ev_tecl && tecla >= 4'd1 && tecla <= PROD_MAX)
      sel_nxt = tecla;
    soma = {1'b0, credito} + {1'b0, valor_moeda(pendente)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      est          <= OCIOSO;
      credito      <= 8'd0;
      produto      <= 4'd0;
      troco        <= 8'd0;
      liberar      <= 1'b0;
      troco_valido <= 1'b0;
      erro         <= 1'b0;
      pendente     <= MOEDA_NADA;
      selecao      <= 4'd0;
      cancela      <= 1'b0;
    end else begin
      liberar      <= 1'b0;
      troco_valido <= 1'b0;
      erro         <= 1'b0;
      if (cancelar)
        cancela <= 1'b1;
      if ((est == OCIOSO || est == COLETA) &&
          moeda != MOEDA_NADA && pendente == MOEDA_NADA)
        pendente <= moeda;
      unique case (est)
        OCIOSO: begin
          if (pendente != MOEDA_NADA || tecla != 4'd0 || cancela)
            est <= COLETA;
        end
        COLETA: begin
          selecao <= sel_nxt;
          if (ev_acum && pendente != MOEDA_NADA) begin
            if (soma <= MAX_V)
              credito <= soma[7:0];
            else
              erro <= 1'b1;
            pendente <= MOEDA_NADA;
          end
          // Decision looks at credit as registered this cycle.
          if (ev_dec) begin
            if (cancela)
              est <= TROCO;
            else if (sel_nxt != 4'd0 && credito >= PRECO_V)
              est <= VENDA;
          end
        end
        VENDA: begin
          liberar <= 1'b1;
          produto <= selecao;
          credito <= credito - PRECO_V;
          est     <= TROCO;
        end
        TROCO: begin
          troco        <= credito;
          troco_valido <= 1'b1;
          credito      <= 8'd0;
          selecao      <= 4'd0;
          cancela      <= 1'b0;
          pendente     <= MOEDA_NADA;
          est          <= OCIOSO;
        end
        default: est <= OCIOSO;
      endcase
    end
  end

  assign estado = est;

endmodule

// File: tb/tb_controle_venda.sv
// Self-checking bench for controle_venda: directed scenarios plus
// random transactions against a transaction-level vending model.
module tb_controle_venda;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tempoTeclado = 1'b1;
  logic       tempoAcumulador = 1'b1;
  logic       tempo = 1'b1;
  logic [1:0] moeda = 2'b00;
  logic [3:0] tecla = 4'd0;
  logic       cancelar = 1'b0;
  logic [1:0] estado;
  logic [7:0] credito;
  logic [3:0] produto;
  logic       liberar;
  logic [7:0] troco;
  logic       troco_valido;
  logic       erro;

  controle_venda dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tempoTeclado    (tempoTeclado),
    .tempoAcumulador (tempoAcumulador),
    .tempo           (tempo),
    .moeda           (moeda),
    .tecla           (tecla),
    .cancelar        (cancelar),
    .estado          (estado),
    .credito         (credito),
    .produto         (produto),
    .liberar         (liberar),
    .troco           (troco),
    .troco_valido    (troco_valido),
    .erro            (erro)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Pulse monitor
  int         n_lib = 0;
  int         n_tv = 0;
  int         n_err = 0;
  logic [7:0] ult_troco = 8'd0;
  logic [3:0] ult_prod = 4'd0;

  always @(negedge clk) begin
    if (liberar) begin
      n_lib = n_lib + 1;
      ult_prod = produto;
    end
    if (troco_valido) begin
      n_tv = n_tv + 1;
      ult_troco = troco;
    end
    if (erro)
      n_err = n_err + 1;
  end

  // Transaction-level model
  int m_cred = 0;
  int m_sel = 0;
  bit m_cancel = 0;
  bit m_active = 0;
  int e_err = 0;
  int e_lib = 0;
  int e_tv = 0;
  int e_troco = 0;
  int e_prod = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_fim();
    m_cred = 0;
    m_sel = 0;
    m_cancel = 0;
    m_active = 0;
  endtask

  task automatic op_moeda(input logic [1:0] c);
    int v;
    v = (c == 2'b01) ? 25 : (c == 2'b10) ? 50 : 100;
    moeda = c;
    tick();
    tick();
    tempoAcumulador = 1'b0;
    tick();
    moeda = 2'b00;
    tempoAcumulador = 1'b1;
    tick();
    m_active = 1;
    if (m_cred + v <= 200) begin
      m_cred = m_cred + v;
      e_err = 0;
    end else begin
      e_err = 1;
    end
  endtask

  task automatic op_tecla(input logic [3:0] k);
    tecla = k;
    tick();
    tick();
    tempoTeclado = 1'b0;
    tick();
    tempoTeclado = 1'b1;
    tecla = 4'd0;
    tick();
    if (m_active || k != 4'd0) begin
      m_active = 1;
      if (k >= 1 && k <= 9)
        m_sel = int'(k);
    end
  endtask

  task automatic op_cancelar();
    cancelar = 1'b1;
    tick();
    cancelar = 1'b0;
    tick();
    m_cancel = 1;
    m_active = 1;
  endtask

  task automatic op_decidir();
    tempo = 1'b0;
    tick();
    tempo = 1'b1;
    tick();
    tick();
    tick();
    e_lib = 0;
    e_tv = 0;
    if (m_active) begin
      if (m_cancel) begin
        e_tv = 1;
        e_troco = m_cred;
        model_fim();
      end else if (m_sel != 0 && m_cred >= 150) begin
        e_lib = 1;
        e_prod = m_sel;
        e_tv = 1;
        e_troco = m_cred - 150;
        model_fim();
      end
    end
  endtask

  task automatic test_reset();
    int l0, t0, r0;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (estado !== 2'd0 || credito !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: estado=%0d credito=%0d expected 0 0",
               estado, credito);
    end
    checks++;
    if (produto !== 4'd0 || troco !== 8'd0 ||
        liberar !== 1'b0 || troco_valido !== 1'b0 || erro !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: produto=%0d troco=%0d pulses=%b%b%b expected 0",
               produto, troco, liberar, troco_valido, erro);
    end
    rst_n = 1'b1;
    l0 = n_lib; t0 = n_tv; r0 = n_err;
    repeat (20) tick();
    checks++;
    if (n_lib != l0 || n_tv != t0 || n_err != r0 ||
        estado !== 2'd0 || credito !== 8'd0) begin
      failures++;
      $display("FAIL reset_idle: pulses=%0d estado=%0d credito=%0d expected 0 0 0",
               (n_lib - l0) + (n_tv - t0) + (n_err - r0), estado, credito);
    end
    model_fim();
  endtask

  task automatic test_venda_basica();
    int l0, t0;
    op_moeda(2'b10);
    checks++;
    if (credito !== 8'd50) begin
      failures++;
      $display("FAIL basic_credit50: credito=%0d expected 50", credito);
    end
    op_moeda(2'b11);
    checks++;
    if (credito !== 8'd150) begin
      failures++;
      $display("FAIL basic_credit150: credito=%0d expected 150", credito);
    end
    op_tecla(4'd3);
    l0 = n_lib; t0 = n_tv;
    op_decidir();
    checks++;
    if (n_lib - l0 != 1 || ult_prod !== 4'd3) begin
      failures++;
      $display("FAIL basic_release: count=%0d produto=%0d expected 1 3",
               n_lib - l0, ult_prod);
    end
    checks++;
    if (n_tv - t0 != 1 || ult_troco !== 8'd0 || estado !== 2'd0) begin
      failures++;
      $display("FAIL basic_change: count=%0d troco=%0d estado=%0d expected 1 0 0",
               n_tv - t0, ult_troco, estado);
    end
  endtask

  task automatic test_rejeicao();
    int r0, l0, t0;
    op_moeda(2'b11);
    op_moeda(2'b11);
    r0 = n_err;
    op_moeda(2'b01);
    checks++;
    if (n_err - r0 != 1 || credito !== 8'd200) begin
      failures++;
      $display("FAIL reject_coin: erro=%0d credito=%0d expected 1 200",
               n_err - r0, credito);
    end
    op_tecla(4'd1);
    l0 = n_lib; t0 = n_tv;
    op_decidir();
    checks++;
    if (n_lib - l0 != 1 || ult_prod !== 4'd1 ||
        n_tv - t0 != 1 || ult_troco !== 8'd50) begin
      failures++;
      $display("FAIL reject_sale: lib=%0d prod=%0d tv=%0d troco=%0d expected 1 1 1 50",
               n_lib - l0, ult_prod, n_tv - t0, ult_troco);
    end
  endtask

  task automatic test_cancelar();
    int l0, t0;
    op_moeda(2'b10);
    op_cancelar();
    l0 = n_lib; t0 = n_tv;
    op_decidir();
    checks++;
    if (n_lib != l0 || n_tv - t0 != 1 || ult_troco !== 8'd50 ||
        credito !== 8'd0) begin
      failures++;
      $display("FAIL cancel_refund: lib=%0d tv=%0d troco=%0d credito=%0d expected 0 1 50 0",
               n_lib - l0, n_tv - t0, ult_troco, credito);
    end
  endtask

  task automatic test_nivel_baixo();
    moeda = 2'b01;
    tick();
    tick();
    tempoAcumulador = 1'b0;
    tick();
    moeda = 2'b00;
    tick();
    tick();
    tick();
    tempoAcumulador = 1'b1;
    tick();
    checks++;
    if (credito !== 8'd25) begin
      failures++;
      $display("FAIL held_low_once: credito=%0d expected 25", credito);
    end
    m_active = 1;
    m_cred = 25;
    op_cancelar();
    op_decidir();
    checks++;
    if (ult_troco !== 8'd25 || estado !== 2'd0) begin
      failures++;
      $display("FAIL held_low_refund: troco=%0d estado=%0d expected 25 0",
               ult_troco, estado);
    end
  endtask

  task automatic test_reset_meio();
    int t0;
    op_moeda(2'b11);
    checks++;
    if (credito !== 8'd100) begin
      failures++;
      $display("FAIL midreset_pre: credito=%0d expected 100", credito);
    end
    t0 = n_tv;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (credito !== 8'd0 || estado !== 2'd0 || n_tv != t0) begin
      failures++;
      $display("FAIL midreset_clear: credito=%0d estado=%0d tv=%0d expected 0 0 0",
               credito, estado, n_tv - t0);
    end
    model_fim();
  endtask

  task automatic test_aleatorio();
    int r, l0, t0, e0;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      l0 = n_lib; t0 = n_tv; e0 = n_err;
      if (r <= 3) begin
        op_moeda(2'($urandom_range(1, 3)));
        checks++;
        if (n_err - e0 != e_err) begin
          failures++;
          $display("FAIL rand_erro[%0d]: got %0d expected %0d",
                   i, n_err - e0, e_err);
        end
      end else if (r <= 5) begin
        op_tecla(4'($urandom_range(0, 12)));
      end else if (r == 6) begin
        op_cancelar();
      end else begin
        op_decidir();
        checks++;
        if (n_lib - l0 != e_lib || n_tv - t0 != e_tv) begin
          failures++;
          $display("FAIL rand_pulses[%0d]: lib=%0d tv=%0d expected %0d %0d",
                   i, n_lib - l0, n_tv - t0, e_lib, e_tv);
        end
        if (e_tv == 1) begin
          checks++;
          if (ult_troco !== 8'(e_troco)) begin
            failures++;
            $display("FAIL rand_troco[%0d]: got %0d expected %0d",
                     i, ult_troco, e_troco);
          end
        end
        if (e_lib == 1) begin
          checks++;
          if (ult_prod !== 4'(e_prod)) begin
            failures++;
            $display("FAIL rand_produto[%0d]: got %0d expected %0d",
                     i, ult_prod, e_prod);
          end
        end
      end
      checks++;
      if (credito !== 8'(m_cred) || estado !== (m_active ? 2'd1 : 2'd0)) begin
        failures++;
        $display("FAIL rand_state[%0d]: credito=%0d estado=%0d expected %0d %0d",
                 i, credito, estado, m_cred, m_active);
      end
    end
    // Drain any open transaction so the run ends idle.
    op_cancelar();
    op_decidir();
    checks++;
    if (estado !== 2'd0 || credito !== 8'd0) begin
      failures++;
      $display("FAIL rand_drain: estado=%0d credito=%0d expected 0 0",
               estado, credito);
    end
  endtask

  initial begin
    test_reset();
    test_venda_basica();
    test_rejeicao();
    test_cancelar();
    test_nivel_baixo();
    test_reset_meio();
    test_aleatorio();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
